// File: rtl/j17_pkg.sv
// Shared types and constants for the J17 control unit: opcode map, FSM states, instruction fields.
package j17_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemrd,
    StExec,
    StHalt
  } state_e;

  localparam logic [4:0] OpMov     = 5'd12;
  localparam logic [4:0] OpStore   = 5'd13;
  localparam logic [4:0] OpHalt    = 5'd15;
  localparam logic [4:0] OpNop     = 5'd16;
  localparam logic [4:0] OpBrFirst = 5'd17;
  localparam logic [4:0] OpBrLast  = 5'd23;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned Op1Msb    = 26;
  localparam int unsigned Op1Lsb    = 24;
  localparam int unsigned ImmBit    = 23;
  localparam int unsigned FlagBit   = 22;
  localparam int unsigned Flag1Bit  = 21;
  localparam int unsigned Op2Msb    = 20;

  typedef struct packed {
    logic [4:0] alucode;
    logic [2:0] pc_control;
    logic [1:0] writecode;
    logic       regenable;
    logic [1:0] ramenable;
    logic       is_halt;
    logic       is_nop;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/j17_if.sv
// Instruction memory fetch channel between the J17 control unit (master) and imem (slave).
interface j17_if #(
    parameter int unsigned IADDR_W = 10
) ();
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic               imem_ready;
  logic [31:0]        imem_data;

  modport master(output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave(input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/j17_decoder.sv
// Combinational opcode decoder producing the J17 datapath control fields.
module j17_decoder
  import j17_pkg::*;
(
    input  logic [4:0] opcode,
    output dec_t       dec
);

  logic [4:0] br_idx;

  always_comb begin
    dec    = '0;
    br_idx = opcode - OpNop;
    if (opcode < OpMov) begin
      dec.alucode   = opcode;
      dec.regenable = 1'b1;
    end else if (opcode == OpMov) begin
      dec.regenable = 1'b1;
      dec.writecode = 2'd1;
    end else if (opcode == OpStore) begin
      dec.ramenable = 2'b01;
    end else if (opcode == OpHalt) begin
      dec.is_halt = 1'b1;
    end else if (opcode == OpNop) begin
      dec.is_nop = 1'b1;
    end else if (opcode >= OpBrFirst && opcode <= OpBrLast) begin
      dec.pc_control = br_idx[2:0];
    end else begin
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/j17_control_unit.sv
// Multi-cycle J17 sequencer: fetch, decode, optional RAM-read wait, execute strobes.
module j17_control_unit
  import j17_pkg::*;
#(
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned FETCH_TIMEOUT = 15,
    parameter int unsigned IADDR_W       = 10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    j17_if.master       imem,
    input  logic [31:0] pc_in,
    output logic [4:0]  alucode,
    output logic [2:0]  op1,
    output logic        imControl,
    output logic        flag,
    output logic        flag1,
    output logic [20:0] op2,
    output logic        regenable,
    output logic [1:0]  ramenable,
    output logic [2:0]  pcControl,
    output logic [1:0]  writecode,
    output logic        pcadvance,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

  localparam int unsigned CntMax = (FETCH_TIMEOUT > MEM_LAT) ? FETCH_TIMEOUT : MEM_LAT;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(FETCH_TIMEOUT - 1);
  localparam logic [CntW-1:0] LatLast = CntW'(MEM_LAT - 1);

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic req_q, req_d;
  logic [IADDR_W-1:0] addr_q, addr_d;
  logic fault_q, fault_d;
  logic enter_exec, load_instr;
  logic regen_q, pcadv_q, busy_q, halted_q;
  logic [1:0] ramen_q;
  logic [15:0] retired_q;
  dec_t dec_new, dec_q;
  logic [2:0] op1_q;
  logic imm_q, flag_q, flag1_q;
  logic [20:0] op2_q;
  logic unused_pc_hi;

  j17_decoder u_decoder (
      .opcode(imem.imem_data[OpcodeMsb:OpcodeLsb]),
      .dec   (dec_new)
  );

  // One counter serves both the fetch timeout and the RAM wait; the states never overlap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
    fault_d    = fault_q;
    enter_exec = 1'b0;
    load_instr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          req_d   = 1'b1;
          addr_d  = pc_in[IADDR_W-1:0];
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (req_q && imem.imem_ready) begin
          state_d    = StDecode;
          load_instr = 1'b1;
        end else if (cnt_q == TmoLast) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          req_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        if (dec_q.is_halt || dec_q.illegal) begin
          state_d = StHalt;
          fault_d = fault_q | dec_q.illegal;
        end else if (flag_q || flag1_q) begin
          state_d = StMemrd;
          cnt_d   = '0;
        end else begin
          state_d    = StExec;
          enter_exec = 1'b1;
        end
      end
      StMemrd: begin
        if (cnt_q == LatLast) begin
          state_d    = StExec;
          enter_exec = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        state_d = StFetch;
        req_d   = 1'b1;
        addr_d  = pc_in[IADDR_W-1:0];
        cnt_d   = '0;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      fault_q   <= 1'b0;
      regen_q   <= 1'b0;
      ramen_q   <= 2'b00;
      pcadv_q   <= 1'b0;
      retired_q <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      dec_q     <= '0;
      op1_q     <= '0;
      imm_q     <= 1'b0;
      flag_q    <= 1'b0;
      flag1_q   <= 1'b0;
      op2_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      fault_q  <= fault_d;
      regen_q  <= enter_exec & dec_q.regenable & ~dec_q.is_nop;
      ramen_q  <= enter_exec ? dec_q.ramenable : 2'b00;
      pcadv_q  <= enter_exec;
      busy_q   <= state_d inside {StFetch, StDecode, StMemrd, StExec};
      halted_q <= (state_d == StHalt);
      if (enter_exec) retired_q <= retired_q + 16'd1;
      if (load_instr) begin
        dec_q   <= dec_new;
        op1_q   <= imem.imem_data[Op1Msb:Op1Lsb];
        imm_q   <= imem.imem_data[ImmBit];
        flag_q  <= imem.imem_data[FlagBit];
        flag1_q <= imem.imem_data[Flag1Bit];
        op2_q   <= imem.imem_data[Op2Msb:0];
      end
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign alucode        = dec_q.alucode;
  assign pcControl      = dec_q.pc_control;
  assign writecode      = dec_q.writecode;
  assign op1            = op1_q;
  assign imControl      = imm_q;
  assign flag           = flag_q;
  assign flag1          = flag1_q;
  assign op2            = op2_q;
  assign regenable      = regen_q;
  assign ramenable      = ramen_q;
  assign pcadvance      = pcadv_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign fault          = fault_q;
  assign retired        = retired_q;
  assign unused_pc_hi   = ^pc_in[31:IADDR_W];

endmodule

// File: tb/tb_j17_control_unit.sv
// Directed bench for j17_control_unit (MEM_LAT=2) with hand-computed expectations.
module tb_j17_control_unit;
  import j17_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] pc_in;
  logic [4:0]  alucode;
  logic [2:0]  op1;
  logic        imControl, flag, flag1;
  logic [20:0] op2;
  logic        regenable;
  logic [1:0]  ramenable;
  logic [2:0]  pcControl;
  logic [1:0]  writecode;
  logic        pcadvance, busy, halted, fault;
  logic [15:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  j17_if #(.IADDR_W(10)) imem_bus ();

  j17_control_unit #(
      .MEM_LAT      (2),
      .FETCH_TIMEOUT(15),
      .IADDR_W      (10)
  ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .start    (start),
      .imem     (imem_bus),
      .pc_in    (pc_in),
      .alucode  (alucode),
      .op1      (op1),
      .imControl(imControl),
      .flag     (flag),
      .flag1    (flag1),
      .op2      (op2),
      .regenable(regenable),
      .ramenable(ramenable),
      .pcControl(pcControl),
      .writecode(writecode),
      .pcadvance(pcadvance),
      .busy     (busy),
      .halted   (halted),
      .fault    (fault),
      .retired  (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    imem_bus.imem_ready = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // From FETCH: present instr with ready for one edge; returns in DECODE.
  task automatic feed(input logic [31:0] instr);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_data  = instr;
    step();
    imem_bus.imem_ready = 1'b0;
  endtask

  int adv_cnt;
  int adv_pos;

  initial begin
    pc_in = 32'h0000_0123;
    imem_bus.imem_data = '0;
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_retired", retired, 0);
    check("rst_req", imem_bus.imem_req, 0);
    check("rst_pcadv", pcadvance, 0);

    // Test 1: ADD r2, imm 5 with imControl; ready immediate
    start = 1'b1;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_data  = 32'h0A80_0005;
    step();
    start = 1'b0;
    check("t1_req", imem_bus.imem_req, 1);
    check("t1_addr", imem_bus.imem_addr, 32'h123);
    check("t1_busy", busy, 1);
    step();
    imem_bus.imem_ready = 1'b0;
    check("t1_alucode", alucode, 1);
    check("t1_op1", op1, 2);
    check("t1_imm", imControl, 1);
    check("t1_op2", op2, 5);
    check("t1_pcadv_early", pcadvance, 0);
    check("t1_req_drop", imem_bus.imem_req, 0);
    step();
    check("t1_regen", regenable, 1);
    check("t1_pcadv", pcadvance, 1);
    check("t1_wcode", writecode, 0);
    check("t1_retired", retired, 1);
    step();
    check("t1_pcadv_off", pcadvance, 0);
    check("t1_regen_off", regenable, 0);
    check("t1_refetch", imem_bus.imem_req, 1);

    // Test 2: MOV with flag=1, two RAM wait cycles
    feed(32'h6040_0007);
    adv_cnt = 0;
    adv_pos = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 1) begin
        check("t2_flag", flag, 1);
        check("t2_wcode", writecode, 1);
      end
      step();
      if (pcadvance) begin
        adv_cnt++;
        adv_pos = i;
      end
      if (i == 2) check("t2_regen_pos", regenable, 0);
      if (i == 3) check("t2_regen", regenable, 1);
    end
    check("t2_adv_count", adv_cnt, 1);
    check("t2_adv_pos", adv_pos, 3);
    check("t2_retired", retired, 2);

    // Test 3: STORE, BEQ, JMP
    feed(32'h6800_0000);
    step();
    check("t3_st_ramen", ramenable, 2'b01);
    check("t3_st_regen", regenable, 0);
    check("t3_st_pcctl", pcControl, 0);
    step();
    check("t3_st_ramen_off", ramenable, 0);
    feed(32'h8800_0000);
    check("t3_beq_pcctl", pcControl, 1);
    step();
    check("t3_beq_adv", pcadvance, 1);
    check("t3_beq_regen", regenable, 0);
    check("t3_beq_ramen", ramenable, 0);
    step();
    feed(32'hB800_0000);
    step();
    check("t3_jmp_pcctl", pcControl, 7);
    check("t3_jmp_regen", regenable, 0);
    check("t3_jmp_adv", pcadvance, 1);
    step();
    check("t3_jmp_hold", pcControl, 7);
    check("t3_retired", retired, 5);

    // Test 4: illegal opcode 14
    feed(32'h7000_0000);
    step();
    check("t4_fault", fault, 1);
    check("t4_halted", halted, 1);
    check("t4_busy", busy, 0);
    check("t4_pcadv", pcadvance, 0);
    check("t4_regen", regenable, 0);
    start = 1'b1;
    step();
    step();
    check("t4_still_halted", halted, 1);
    check("t4_no_req", imem_bus.imem_req, 0);
    check("t4_retired", retired, 5);
    resetn = 1'b0;
    step();
    check("t4_rst_wins_busy", busy, 0);
    check("t4_rst_fault", fault, 0);
    check("t4_rst_halted", halted, 0);
    start  = 1'b0;
    resetn = 1'b1;

    // Test 5a: fetch timeout after 15 cycles without ready
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("t5_no_fault_14", fault, 0);
    check("t5_req_14", imem_bus.imem_req, 1);
    step();
    check("t5_fault", fault, 1);
    check("t5_req_drop", imem_bus.imem_req, 0);
    check("t5_halted", halted, 1);
    do_reset();

    // Test 5b: ready on the 14th fetch cycle, NOP
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    feed(32'h8000_0000);
    check("t5b_fault", fault, 0);
    check("t5b_busy", busy, 1);
    step();
    check("t5b_nop_adv", pcadvance, 1);
    check("t5b_nop_regen", regenable, 0);
    check("t5b_retired", retired, 1);
    step();
    check("t5b_fault_after", fault, 0);

    // Test 6: reset during MEMRD, and during FETCH
    feed(32'h6040_0007);
    step();
    check("t6_in_memrd", pcadvance, 0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("t6_busy", busy, 0);
    check("t6_wcode", writecode, 0);
    check("t6_op2", op2, 0);
    check("t6_flag", flag, 0);
    check("t6_retired", retired, 0);
    check("t6_req", imem_bus.imem_req, 0);
    step();
    step();
    check("t6_no_adv", pcadvance, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_fetch_req", imem_bus.imem_req, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("t6_fetch_rst_req", imem_bus.imem_req, 0);
    check("t6_fetch_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
